disp_bcd_source: RTL and testbench

//  Upstream data source for the 8-digit dynamic seven-segment display path.

---
 rtl/disp_bcd_source.sv | 152 +++++++++++++++
 tb/tb_disp_bcd_source.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/disp_bcd_source.sv
// 8-digit packed-BCD counter with prescaler tick and scanner-driven digit readout.
// Optional: define LEADING_ZERO_BLANK_EN to blank leading zero digits (digit0 always shown).
module disp_bcd_source #(
    parameter logic [25:0] CNT_MAX = 26'd50_000_000,
    parameter logic [3:0]  BLANK   = 4'hF
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        en,
    input  logic        clr,
    input  logic        load,
    input  logic [31:0] load_val,
    input  logic [7:0]  Led_cnt,
    output logic [3:0]  digit,
    output logic        tick,
    output logic        ovf,
    output logic        sel_err
);

    logic [25:0] pc_q, pc_d;
    logic [31:0] bcd_q, bcd_d;
    logic        tick_q, tick_d;
    logic        ovf_q, ovf_d;
    logic [3:0]  digit_q, digit_d;
    logic        sel_err_q, sel_err_d;

    logic [31:0] bcd_inc;
    logic        inc_carry;
    logic [31:0] bcd_clamp;
    logic [3:0]  nib;
    logic [3:0]  ld_nib;

    logic [7:0]  led_low;
    logic        sel_ok;
    logic [3:0]  sel_nib;
    logic        sel_blank;
    logic [7:0]  blank_mask;
`ifdef LEADING_ZERO_BLANK_EN
    logic        zero_run;
`endif

    assign digit   = digit_q;
    assign tick    = tick_q;
    assign ovf     = ovf_q;
    assign sel_err = sel_err_q;

    // Decimal increment; carry ripples through all eight digits in one cycle.
    always_comb begin
        bcd_inc   = bcd_q;
        inc_carry = 1'b1;
        nib       = 4'd0;
        for (int i = 0; i < 8; i++) begin
            nib = bcd_q[4*i +: 4];
            if (inc_carry) begin
                if (nib == 4'd9) begin
                    bcd_inc[4*i +: 4] = 4'd0;
                end else begin
                    bcd_inc[4*i +: 4] = nib + 4'd1;
                    inc_carry         = 1'b0;
                end
            end
        end
    end

    always_comb begin
        bcd_clamp = '0;
        ld_nib    = 4'd0;
        for (int i = 0; i < 8; i++) begin
            ld_nib               = load_val[4*i +: 4];
            bcd_clamp[4*i +: 4] = (ld_nib > 4'd9) ? 4'd9 : ld_nib;
        end
    end

    always_comb begin
        pc_d   = pc_q;
        tick_d = 1'b0;
        bcd_d  = bcd_q;
        ovf_d  = ovf_q;
        if (clr) begin
            pc_d  = '0;
            bcd_d = '0;
            ovf_d = 1'b0;
        end else if (load) begin
            // A tick arriving this cycle is dropped along with the prescaler phase.
            pc_d  = '0;
            bcd_d = bcd_clamp;
        end else begin
            if (tick_q) begin
                bcd_d = bcd_inc;
                if (inc_carry) begin
                    ovf_d = 1'b1;
                end
            end
            if (en) begin
                if (pc_q == CNT_MAX - 26'd1) begin
                    pc_d   = '0;
                    tick_d = 1'b1;
                end else begin
                    pc_d = pc_q + 26'd1;
                end
            end
        end
    end

    // Readout uses the counter contents before this edge's update.
    always_comb begin
        led_low    = ~Led_cnt;
        sel_ok     = (led_low != 8'd0) && ((led_low & (led_low - 8'd1)) == 8'd0);
        blank_mask = '0;
        sel_nib    = 4'd0;
        sel_blank  = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
        zero_run = 1'b1;
        for (int i = 7; i >= 1; i--) begin
            zero_run      = zero_run && (bcd_q[4*i +: 4] == 4'd0);
            blank_mask[i] = zero_run;
        end
`endif
        for (int i = 0; i < 8; i++) begin
            if (!Led_cnt[i]) begin
                sel_nib   = bcd_q[4*i +: 4];
                sel_blank = blank_mask[i];
            end
        end
        if (!sel_ok) begin
            digit_d   = BLANK;
            sel_err_d = 1'b1;
        end else begin
            digit_d   = sel_blank ? BLANK : sel_nib;
            sel_err_d = 1'b0;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            pc_q      <= '0;
            bcd_q     <= '0;
            tick_q    <= 1'b0;
            ovf_q     <= 1'b0;
            digit_q   <= 4'h0;
            sel_err_q <= 1'b0;
        end else begin
            pc_q      <= pc_d;
            bcd_q     <= bcd_d;
            tick_q    <= tick_d;
            ovf_q     <= ovf_d;
            digit_q   <= digit_d;
            sel_err_q <= sel_err_d;
        end
    end

endmodule

// File: tb/tb_disp_bcd_source.sv
// Bench for disp_bcd_source: decimal-arithmetic reference model, per-cycle compare,
// directed scenarios with literal expectations, then randomized traffic.
module tb_disp_bcd_source;

    localparam int unsigned CMAX = 4;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic        en = 1'b0;
    logic        clr = 1'b0;
    logic        load = 1'b0;
    logic [31:0] load_val = '0;
    logic [7:0]  Led_cnt = 8'hFE;
    logic [3:0]  digit;
    logic        tick;
    logic        ovf;
    logic        sel_err;

    int tests = 0;
    int fails = 0;
    bit chk_en = 0;

    // Reference model state: counter held as a plain decimal integer.
    int unsigned m_cnt = 0;
    int unsigned m_pc = 0;
    bit          m_tick = 0;
    bit          m_ovf = 0;
    logic [3:0]  m_digit = 4'h0;
    bit          m_serr = 0;

    disp_bcd_source #(
        .CNT_MAX(26'd4),
        .BLANK  (4'hF)
    ) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .en      (en),
        .clr     (clr),
        .load    (load),
        .load_val(load_val),
        .Led_cnt (Led_cnt),
        .digit   (digit),
        .tick    (tick),
        .ovf     (ovf),
        .sel_err (sel_err)
    );

    always #5 sys_clk = ~sys_clk;

    function automatic int unsigned clamp_val(input logic [31:0] v);
        int unsigned r;
        int unsigned p;
        logic [3:0]  n;
        r = 0;
        p = 1;
        for (int i = 0; i < 8; i++) begin
            n = v[4*i +: 4];
            r += (n > 4'd9 ? 32'd9 : {28'd0, n}) * p;
            p *= 10;
        end
        return r;
    endfunction

    function automatic logic [4:0] readout(input int unsigned cnt, input logic [7:0] led);
        int unsigned idx;
        int unsigned p;
        if ($countones(~led) != 1) return {1'b1, 4'hF};
        idx = 0;
        for (int i = 0; i < 8; i++) if (!led[i]) idx = i;
        p = 1;
        for (int i = 0; i < 8; i++) if (i < idx) p *= 10;
`ifdef LEADING_ZERO_BLANK_EN
        if (idx != 0 && cnt < p) return {1'b0, 4'hF};
`endif
        return {1'b0, 4'((cnt / p) % 10)};
    endfunction

    always @(posedge sys_clk) begin
        if (sys_rst) begin
            m_cnt   <= 0;
            m_pc    <= 0;
            m_tick  <= 0;
            m_ovf   <= 0;
            m_digit <= 4'h0;
            m_serr  <= 0;
        end else begin
            {m_serr, m_digit} <= readout(m_cnt, Led_cnt);
            if (clr) begin
                m_cnt  <= 0;
                m_pc   <= 0;
                m_ovf  <= 0;
                m_tick <= 0;
            end else if (load) begin
                m_cnt  <= clamp_val(load_val);
                m_pc   <= 0;
                m_tick <= 0;
            end else begin
                if (m_tick) begin
                    m_cnt <= (m_cnt + 1) % 100000000;
                    if (m_cnt == 99999999) m_ovf <= 1;
                end
                if (en && m_pc == CMAX - 1) begin
                    m_pc   <= 0;
                    m_tick <= 1;
                end else begin
                    if (en) m_pc <= m_pc + 1;
                    m_tick <= 0;
                end
            end
        end
    end

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge sys_clk) begin
        if (chk_en) begin
            check("cmp_digit", digit, m_digit);
            check("cmp_tick", tick, m_tick);
            check("cmp_ovf", ovf, m_ovf);
            check("cmp_sel_err", sel_err, m_serr);
        end
    end

    task automatic wait_tick(input string name);
        bit seen;
        seen = 0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge sys_clk);
            if (tick) seen = 1;
        end
        tests++;
        if (!seen) begin
            fails++;
            $display("FAIL %s: tick got 0 within 20 cycles, required 1", name);
        end
    endtask

    task automatic do_load(input logic [31:0] v);
        load     = 1'b1;
        load_val = v;
        @(negedge sys_clk);
        load = 1'b0;
    endtask

    initial begin
        // Reset
        repeat (2) @(negedge sys_clk);
        check("rst_digit", digit, 0);
        check("rst_tick", tick, 0);
        check("rst_ovf", ovf, 0);
        check("rst_sel_err", sel_err, 0);
        sys_rst = 1'b0;
        en      = 1'b1;
        chk_en  = 1;

        // Counting: ticks on cycles 4, 8, 12
        for (int k = 1; k <= 12; k++) begin
            @(negedge sys_clk);
            check("count_tick", tick, (k % 4 == 0) ? 1 : 0);
        end
        en = 1'b0;
        repeat (2) @(negedge sys_clk);
        check("count_digit", digit, 3);
        repeat (3) @(negedge sys_clk);
        check("count_hold", digit, 3);

        // Carry ripple 0999 -> 1000
        en = 1'b1;
        do_load(32'h0000_0999);
        wait_tick("ripple_tick");
        en = 1'b0;
        @(negedge sys_clk);
        Led_cnt = 8'hF7;
        @(negedge sys_clk);
        check("ripple_d3", digit, 1);
        Led_cnt = 8'hFB;
        @(negedge sys_clk);
        check("ripple_d2", digit, 0);

        // Wrap and clear
        en = 1'b1;
        do_load(32'h9999_9999);
        wait_tick("wrap_tick");
        en = 1'b0;
        Led_cnt = 8'hFE;
        repeat (2) @(negedge sys_clk);
        check("wrap_ovf", ovf, 1);
        check("wrap_digit", digit, 0);
        clr = 1'b1;
        @(negedge sys_clk);
        clr = 1'b0;
        check("clr_ovf", ovf, 0);
        en = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge sys_clk);
            check("clr_pc_tick", tick, (k == 4) ? 1 : 0);
        end
        en = 1'b0;
        @(negedge sys_clk);

        // Load in tick cycle with clamp; clr beats load
        en = 1'b1;
        wait_tick("prio_tick");
        do_load(32'h0000_00A5);
        en = 1'b0;
        Led_cnt = 8'hFE;
        @(negedge sys_clk);
        check("clamp_d0", digit, 5);
        Led_cnt = 8'hFD;
        @(negedge sys_clk);
        check("clamp_d1", digit, 9);
        clr      = 1'b1;
        load     = 1'b1;
        load_val = 32'h1234_5678;
        Led_cnt  = 8'hFE;
        @(negedge sys_clk);
        clr  = 1'b0;
        load = 1'b0;
        @(negedge sys_clk);
        check("clrload_d0", digit, 0);

        // Select errors and leading-zero behaviour
        Led_cnt = 8'hFC;
        @(negedge sys_clk);
        check("selerr2_digit", digit, 4'hF);
        check("selerr2_flag", sel_err, 1);
        Led_cnt = 8'hFF;
        @(negedge sys_clk);
        check("selerr0_digit", digit, 4'hF);
        check("selerr0_flag", sel_err, 1);
        Led_cnt = 8'hDF;
        do_load(32'h0000_0042);
        @(negedge sys_clk);
`ifdef LEADING_ZERO_BLANK_EN
        check("lzb_d5", digit, 4'hF);
`else
        check("lzb_d5", digit, 0);
`endif
        check("lzb_sel_err", sel_err, 0);
        Led_cnt = 8'hFE;
        @(negedge sys_clk);
        check("val_d0", digit, 2);

        // Randomized traffic
        for (int k = 0; k < 3000; k++) begin
            sys_rst = ($urandom_range(0, 499) == 0);
            en      = ($urandom_range(0, 7) != 0);
            clr     = ($urandom_range(0, 63) == 0);
            load    = ($urandom_range(0, 31) == 0);
            if ($urandom_range(0, 1) == 0)
                load_val = {28'h9999_999, 4'($urandom_range(0, 15))};
            else
                load_val = $urandom;
            if ($urandom_range(0, 9) == 0)
                Led_cnt = 8'($urandom);
            else
                Led_cnt = ~(8'd1 << $urandom_range(0, 7));
            @(negedge sys_clk);
        end

        chk_en  = 0;
        sys_rst = 1'b0;
        clr     = 1'b0;
        load    = 1'b0;
        en      = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
